// File: rtl/sb_msg_req_queue.sv
`default_nettype none
// sb_msg_req_queue: LTSM request FIFO plus single-entry RDI slot arbitrated onto the sideband TX
// with busy handshake and accept timeout. Optional drop statistics: SB_MSG_REQ_QUEUE_STATS_EN.
module sb_msg_req_queue #(
    parameter int DEPTH          = 4,
    parameter int ACCEPT_TIMEOUT = 32
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_flush,
    input  logic        i_ltsm_valid,
    output logic        o_ltsm_ready,
    input  logic [3:0]  i_state,
    input  logic [3:0]  i_sub_state,
    input  logic [3:0]  i_msg_no,
    input  logic [2:0]  i_msg_info,
    input  logic [15:0] i_data_bus,
    input  logic        i_data_valid,
    input  logic        i_rdi_valid,
    output logic        o_rdi_ready,
    input  logic [1:0]  i_rdi_msg_code,
    input  logic [3:0]  i_rdi_msg_sub_code,
    input  logic [1:0]  i_rdi_msg_info,
    input  logic        i_busy,
    output logic        o_msg_valid,
    output logic        o_rdi_msg,
    output logic [3:0]  o_state,
    output logic [3:0]  o_sub_state,
    output logic [3:0]  o_msg_no,
    output logic [2:0]  o_msg_info,
    output logic [15:0] o_data_bus,
    output logic        o_data_valid,
    output logic [1:0]  o_rdi_msg_code,
    output logic [3:0]  o_rdi_msg_sub_code,
    output logic [1:0]  o_rdi_msg_info,
`ifdef SB_MSG_REQ_QUEUE_STATS_EN
    output logic [7:0]  o_drop_cnt,
`endif
    output logic        o_timeout_err
);

    localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNTW = AW + 1;
    localparam int TW   = $clog2(ACCEPT_TIMEOUT + 1);
    localparam logic [CNTW-1:0] FULL_CNT = CNTW'(DEPTH);
    localparam logic [TW-1:0]   TO_LAST  = TW'(ACCEPT_TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE        = 2'd0,
        ISSUE       = 2'd1,
        WAIT_ACCEPT = 2'd2,
        WAIT_DONE   = 2'd3
    } state_e;

    state_e          state_q, state_d;
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNTW-1:0] count_q, count_d;
    logic [31:0]     mem_q [DEPTH];
    logic            rdi_full_q, rdi_full_d;
    logic [7:0]      rdi_entry_q, rdi_entry_d;
    logic            src_rdi_q, src_rdi_d;
    logic [TW-1:0]   tmo_cnt_q, tmo_cnt_d;
    logic [31:0]     ltsm_out_q;
    logic [7:0]      rdi_out_q;

    logic        fifo_full, fifo_empty;
    logic        push, rdi_push, pop_ltsm, pop_rdi;
    logic        load, retire, timeout;
    logic [31:0] w_entry, fifo_head;

    assign fifo_full  = (count_q == FULL_CNT);
    assign fifo_empty = (count_q == '0);
    assign push       = i_ltsm_valid && !fifo_full;
    assign rdi_push   = i_rdi_valid && !rdi_full_q;
    assign pop_ltsm   = retire && !src_rdi_q;
    assign pop_rdi    = retire && src_rdi_q;
    assign w_entry    = {i_state, i_sub_state, i_msg_no, i_msg_info, i_data_valid, i_data_bus};
    assign fifo_head  = mem_q[rd_ptr_q];

    // Sequencer: the RDI slot has priority; an entry leaves the queue only when retired.
    always_comb begin
        state_d   = state_q;
        src_rdi_d = src_rdi_q;
        tmo_cnt_d = '0;
        load      = 1'b0;
        retire    = 1'b0;
        timeout   = 1'b0;
        case (state_q)
            IDLE: begin
                if (rdi_full_q || !fifo_empty) begin
                    state_d   = ISSUE;
                    src_rdi_d = rdi_full_q;
                    load      = 1'b1;
                end
            end
            ISSUE: state_d = WAIT_ACCEPT;
            WAIT_ACCEPT: begin
                if (i_busy) begin
                    state_d = WAIT_DONE;
                end else if (tmo_cnt_q == TO_LAST) begin
                    state_d = IDLE;
                    timeout = 1'b1;
                    retire  = 1'b1;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + 1'b1;
                end
            end
            WAIT_DONE: begin
                if (!i_busy) begin
                    state_d = IDLE;
                    retire  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        if (i_flush) begin
            state_d   = IDLE;
            tmo_cnt_d = '0;
            load      = 1'b0;
            retire    = 1'b0;
            timeout   = 1'b0;
        end
    end

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        rdi_full_d  = rdi_full_q;
        rdi_entry_d = rdi_entry_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop_ltsm) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({push, pop_ltsm})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
        if (pop_rdi) begin
            rdi_full_d = 1'b0;
        end
        if (rdi_push) begin
            rdi_full_d  = 1'b1;
            rdi_entry_d = {i_rdi_msg_code, i_rdi_msg_sub_code, i_rdi_msg_info};
        end
        if (i_flush) begin
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            count_d    = '0;
            rdi_full_d = 1'b0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (push && !i_flush) begin
            mem_q[wr_ptr_q] <= w_entry;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q     <= IDLE;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            rdi_full_q  <= 1'b0;
            rdi_entry_q <= '0;
            src_rdi_q   <= 1'b0;
            tmo_cnt_q   <= '0;
            ltsm_out_q  <= '0;
            rdi_out_q   <= '0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            rdi_full_q  <= rdi_full_d;
            rdi_entry_q <= rdi_entry_d;
            src_rdi_q   <= src_rdi_d;
            tmo_cnt_q   <= tmo_cnt_d;
            // Issued fields are captured once per transaction; the other path keeps its last value.
            if (load) begin
                if (rdi_full_q) begin
                    rdi_out_q <= rdi_entry_q;
                end else begin
                    ltsm_out_q <= fifo_head;
                end
            end
        end
    end

    assign o_ltsm_ready  = !fifo_full;
    assign o_rdi_ready   = !rdi_full_q;
    assign o_msg_valid   = (state_q == ISSUE) && !src_rdi_q;
    assign o_rdi_msg     = (state_q == ISSUE) && src_rdi_q;
    assign o_timeout_err = timeout;
    assign {o_state, o_sub_state, o_msg_no, o_msg_info, o_data_valid, o_data_bus} = ltsm_out_q;
    assign {o_rdi_msg_code, o_rdi_msg_sub_code, o_rdi_msg_info} = rdi_out_q;

`ifdef SB_MSG_REQ_QUEUE_STATS_EN
    logic [7:0] drop_cnt_q;
    logic [1:0] drop_inc;
    logic [8:0] drop_sum;

    always_comb begin
        drop_inc = {1'b0, (i_ltsm_valid && fifo_full && !i_flush)} + {1'b0, timeout};
        drop_sum = {1'b0, drop_cnt_q} + {7'b0, drop_inc};
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            drop_cnt_q <= '0;
        end else begin
            drop_cnt_q <= drop_sum[8] ? 8'hFF : drop_sum[7:0];
        end
    end

    assign o_drop_cnt = drop_cnt_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_sb_msg_req_queue.sv
`default_nettype none
// Scoreboard bench for sb_msg_req_queue: directed LTSM/RDI traffic against a busy responder,
// covering latency, priority, full/drop, accept timeout, flush and mid-transaction reset.
module tb_sb_msg_req_queue;
    localparam int DEPTH          = 4;
    localparam int ACCEPT_TIMEOUT = 32;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        i_flush, i_ltsm_valid, i_data_valid, i_rdi_valid, i_busy;
    logic [3:0]  i_state, i_sub_state, i_msg_no, i_rdi_msg_sub_code;
    logic [2:0]  i_msg_info;
    logic [15:0] i_data_bus;
    logic [1:0]  i_rdi_msg_code, i_rdi_msg_info;
    logic        o_ltsm_ready, o_rdi_ready, o_msg_valid, o_rdi_msg, o_data_valid, o_timeout_err;
    logic [3:0]  o_state, o_sub_state, o_msg_no, o_rdi_msg_sub_code;
    logic [2:0]  o_msg_info;
    logic [15:0] o_data_bus;
    logic [1:0]  o_rdi_msg_code, o_rdi_msg_info;
`ifdef SB_MSG_REQ_QUEUE_STATS_EN
    logic [7:0]  o_drop_cnt;
`endif

    always #5 clk = ~clk;

    sb_msg_req_queue #(.DEPTH(DEPTH), .ACCEPT_TIMEOUT(ACCEPT_TIMEOUT)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_flush(i_flush),
        .i_ltsm_valid(i_ltsm_valid), .o_ltsm_ready(o_ltsm_ready),
        .i_state(i_state), .i_sub_state(i_sub_state), .i_msg_no(i_msg_no),
        .i_msg_info(i_msg_info), .i_data_bus(i_data_bus), .i_data_valid(i_data_valid),
        .i_rdi_valid(i_rdi_valid), .o_rdi_ready(o_rdi_ready),
        .i_rdi_msg_code(i_rdi_msg_code), .i_rdi_msg_sub_code(i_rdi_msg_sub_code),
        .i_rdi_msg_info(i_rdi_msg_info), .i_busy(i_busy),
        .o_msg_valid(o_msg_valid), .o_rdi_msg(o_rdi_msg),
        .o_state(o_state), .o_sub_state(o_sub_state), .o_msg_no(o_msg_no),
        .o_msg_info(o_msg_info), .o_data_bus(o_data_bus), .o_data_valid(o_data_valid),
        .o_rdi_msg_code(o_rdi_msg_code), .o_rdi_msg_sub_code(o_rdi_msg_sub_code),
        .o_rdi_msg_info(o_rdi_msg_info),
`ifdef SB_MSG_REQ_QUEUE_STATS_EN
        .o_drop_cnt(o_drop_cnt),
`endif
        .o_timeout_err(o_timeout_err)
    );

    typedef struct packed {
        logic        rdi;
        logic [31:0] ltsm;
        logic [7:0]  rdif;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    int   n_checks = 0, n_pass = 0;
    int   cyc = 0;
    int   issue_cnt = 0, to_cnt = 0;
    int   last_issue_cyc = 0, last_rdi_cyc = 0, last_ltsm_cyc = 0, last_to_cyc = 0;
    int   resp_mode = 1;
    int   base, tbase, push_edge, t_issue;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    function automatic exp_t mk_ltsm(input logic [3:0] st, input logic [3:0] sub, input logic [3:0] no,
                                     input logic [2:0] info, input logic dv, input logic [15:0] d);
        exp_t e;
        e.rdi  = 1'b0;
        e.ltsm = {st, sub, no, info, dv, d};
        e.rdif = 8'h00;
        return e;
    endfunction

    function automatic exp_t mk_rdi(input logic [1:0] code, input logic [3:0] sub, input logic [1:0] info);
        exp_t e;
        e.rdi  = 1'b1;
        e.ltsm = 32'h0;
        e.rdif = {code, sub, info};
        return e;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_ltsm(input exp_t e);
        i_ltsm_valid = 1'b1;
        {i_state, i_sub_state, i_msg_no, i_msg_info, i_data_valid, i_data_bus} = e.ltsm;
    endtask

    task automatic drive_rdi(input exp_t e);
        i_rdi_valid = 1'b1;
        {i_rdi_msg_code, i_rdi_msg_sub_code, i_rdi_msg_info} = e.rdif;
    endtask

    task automatic wait_issues(input int target, input int bound, input string name);
        int n = 0;
        while (issue_cnt < target && n < bound) begin
            @(posedge clk);
            n++;
        end
        check(name, 32'(issue_cnt >= target), 32'd1);
    endtask

    task automatic wait_timeouts(input int target, input int bound, input string name);
        int n = 0;
        while (to_cnt < target && n < bound) begin
            @(posedge clk);
            n++;
        end
        check(name, 32'(to_cnt >= target), 32'd1);
    endtask

    // Monitor: every issue pulse is matched against the oldest expected message.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (o_msg_valid || o_rdi_msg) begin
                    issue_cnt++;
                    last_issue_cyc = cyc;
                    if (o_rdi_msg) last_rdi_cyc = cyc;
                    else last_ltsm_cyc = cyc;
                    if (sb_q.size() == 0) begin
                        check("unexpected_issue", {30'd0, o_rdi_msg, o_msg_valid}, 32'd0);
                    end else begin
                        mon_e = sb_q.pop_front();
                        check("issue_kind", {30'd0, o_rdi_msg, o_msg_valid}, mon_e.rdi ? 32'd2 : 32'd1);
                        if (mon_e.rdi)
                            check("rdi_fields", {24'd0, o_rdi_msg_code, o_rdi_msg_sub_code, o_rdi_msg_info},
                                  {24'd0, mon_e.rdif});
                        else
                            check("ltsm_fields", {o_state, o_sub_state, o_msg_no, o_msg_info,
                                                  o_data_valid, o_data_bus}, mon_e.ltsm);
                    end
                end
                if (o_timeout_err) begin
                    to_cnt++;
                    last_to_cyc = cyc;
                end
            end
        end
    end

    // Responder: busy rises 3 cycles after an issue and stays high for 10 cycles.
    initial begin
        i_busy = 1'b0;
        forever begin
            @(negedge clk);
            if (rst_n && resp_mode == 1 && (o_msg_valid || o_rdi_msg)) begin
                repeat (3) @(posedge clk);
                #1 i_busy = 1'b1;
                repeat (10) @(posedge clk);
                #1 i_busy = 1'b0;
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
        $fatal(1);
    end

    initial begin
        i_flush = 0; i_ltsm_valid = 0; i_rdi_valid = 0;
        i_state = 0; i_sub_state = 0; i_msg_no = 0; i_msg_info = 0; i_data_bus = 0; i_data_valid = 0;
        i_rdi_msg_code = 0; i_rdi_msg_sub_code = 0; i_rdi_msg_info = 0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_ltsm_ready", 32'(o_ltsm_ready), 32'd1);
        check("rst_rdi_ready", 32'(o_rdi_ready), 32'd1);
        check("rst_pulses", {29'd0, o_msg_valid, o_rdi_msg, o_timeout_err}, 32'd0);
        check("rst_fields", {o_state, o_sub_state, o_msg_no, o_msg_info, o_data_valid, o_data_bus}, 32'd0);
        @(negedge clk) rst_n = 1'b1;
        tick();

        // Single LTSM message: latency, field stability, empty afterwards.
        resp_mode = 1;
        base = issue_cnt;
        sb_q.push_back(mk_ltsm(4'h1, 4'h2, 4'h5, 3'h3, 1'b1, 16'hA5A5));
        drive_ltsm(mk_ltsm(4'h1, 4'h2, 4'h5, 3'h3, 1'b1, 16'hA5A5));
        push_edge = cyc + 1;
        tick();
        i_ltsm_valid = 1'b0;
        wait_issues(base + 1, 20, "a_issue_wait");
        check("a_latency", last_issue_cyc, push_edge + 1);
        for (int n = 0; n < 20 && !i_busy; n++) @(posedge clk);
        @(negedge clk);
        check("a_fields_busy", {o_msg_no, o_data_bus}, {16'd0, 4'h5, 16'hA5A5});
        for (int n = 0; n < 20 && i_busy; n++) @(posedge clk);
        @(negedge clk);
        check("a_fields_after", {o_msg_no, o_data_bus}, {16'd0, 4'h5, 16'hA5A5});
        repeat (20) @(posedge clk);
        check("a_single_issue", issue_cnt - base, 1);
        check("a_ready_after", 32'(o_ltsm_ready), 32'd1);
        check("a_sb_empty", sb_q.size(), 0);

        // LTSM and RDI pushed together: RDI first, LTSM after the RDI busy cycle completes.
        #1;
        base = issue_cnt;
        sb_q.push_back(mk_rdi(2'h2, 4'h9, 2'h1));
        sb_q.push_back(mk_ltsm(4'h7, 4'h3, 4'hC, 3'h6, 1'b0, 16'h1234));
        drive_ltsm(mk_ltsm(4'h7, 4'h3, 4'hC, 3'h6, 1'b0, 16'h1234));
        drive_rdi(mk_rdi(2'h2, 4'h9, 2'h1));
        tick();
        i_ltsm_valid = 1'b0;
        i_rdi_valid  = 1'b0;
        @(negedge clk);
        check("b_rdi_ready_low", 32'(o_rdi_ready), 32'd0);
        wait_issues(base + 2, 80, "b_issue_wait");
        check("b_order_gap", last_ltsm_cyc - last_rdi_cyc, 15);
        repeat (30) @(posedge clk);
        check("b_sb_empty", sb_q.size(), 0);
        check("b_rdi_ready_after", 32'(o_rdi_ready), 32'd1);

        // Fill with busy held low: fifth push dropped, each entry times out in turn.
        #1;
        resp_mode = 0;
        base  = issue_cnt;
        tbase = to_cnt;
        for (int i = 0; i < 4; i++) begin
            sb_q.push_back(mk_ltsm(4'(i), 4'(15 - i), 4'(i + 8), 3'(i), 1'b1, 16'(16'hB000 + i)));
            drive_ltsm(mk_ltsm(4'(i), 4'(15 - i), 4'(i + 8), 3'(i), 1'b1, 16'(16'hB000 + i)));
            tick();
        end
        drive_ltsm(mk_ltsm(4'hF, 4'hF, 4'hF, 3'h7, 1'b0, 16'hDEAD));
        @(negedge clk);
        check("c_ready_low_full", 32'(o_ltsm_ready), 32'd0);
        tick();
        i_ltsm_valid = 1'b0;
`ifdef SB_MSG_REQ_QUEUE_STATS_EN
        @(negedge clk);
        check("c_drop_cnt", 32'(o_drop_cnt), 32'd1);
`endif
        wait_issues(base + 1, 10, "c_issue_wait");
        t_issue = last_issue_cyc;
        wait_timeouts(tbase + 1, 60, "c_timeout_wait");
        check("c_timeout_latency", last_to_cyc - t_issue, ACCEPT_TIMEOUT);
        wait_issues(base + 2, 10, "c_reissue_wait");
        check("c_reissue_gap", last_issue_cyc - last_to_cyc, 2);
        wait_timeouts(tbase + 4, 200, "c_all_timeouts_wait");
        repeat (40) @(posedge clk);
        check("c_timeout_count", to_cnt - tbase, 4);
        check("c_issue_count", issue_cnt - base, 4);
        check("c_sb_empty", sb_q.size(), 0);

        // Flush while in WAIT_DONE with three LTSM entries and an RDI request queued.
        #1;
        resp_mode = 1;
        base = issue_cnt;
        sb_q.push_back(mk_ltsm(4'h3, 4'h1, 4'h2, 3'h4, 1'b1, 16'h0F0F));
        for (int i = 0; i < 4; i++) begin
            drive_ltsm(mk_ltsm(4'h3, 4'h1, 4'(i + 2), 3'h4, 1'b1, 16'(16'h0F0F + i)));
            tick();
        end
        i_ltsm_valid = 1'b0;
        drive_rdi(mk_rdi(2'h1, 4'h4, 2'h3));
        tick();
        i_rdi_valid = 1'b0;
        repeat (3) tick();
        i_flush = 1'b1;
        tick();
        i_flush = 1'b0;
        @(negedge clk);
        check("d_ltsm_ready", 32'(o_ltsm_ready), 32'd1);
        check("d_rdi_ready", 32'(o_rdi_ready), 32'd1);
        repeat (60) @(posedge clk);
        check("d_no_more_issues", issue_cnt - base, 1);
        check("d_sb_empty", sb_q.size(), 0);

        // Asynchronous reset while waiting for accept.
        #1;
        resp_mode = 0;
        base  = issue_cnt;
        tbase = to_cnt;
        sb_q.push_back(mk_ltsm(4'h9, 4'h8, 4'h7, 3'h2, 1'b1, 16'h5A5A));
        drive_ltsm(mk_ltsm(4'h9, 4'h8, 4'h7, 3'h2, 1'b1, 16'h5A5A));
        tick();
        drive_ltsm(mk_ltsm(4'h1, 4'h1, 4'h1, 3'h1, 1'b1, 16'h1111));
        tick();
        i_ltsm_valid = 1'b0;
        wait_issues(base + 1, 10, "e_issue_wait");
        repeat (4) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check("e_rst_readies", {30'd0, o_ltsm_ready, o_rdi_ready}, 32'd3);
        check("e_rst_pulses", {29'd0, o_msg_valid, o_rdi_msg, o_timeout_err}, 32'd0);
        check("e_rst_fields", {o_state, o_sub_state, o_msg_no, o_msg_info, o_data_valid, o_data_bus}, 32'd0);
        check("e_rst_rdi_fields", {24'd0, o_rdi_msg_code, o_rdi_msg_sub_code, o_rdi_msg_info}, 32'd0);
`ifdef SB_MSG_REQ_QUEUE_STATS_EN
        check("e_rst_drop_cnt", 32'(o_drop_cnt), 32'd0);
`endif
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        repeat (60) @(posedge clk);
        check("e_no_issue_after_rst", issue_cnt - base, 1);
        check("e_no_timeout_after_rst", to_cnt - tbase, 0);
        check("e_sb_empty", sb_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
